// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for pipe_stage_reg: upstream offer, downstream head, status.
interface pipe_stage_reg_if #(
   parameter int DATA_W = 96,
   parameter int CTRL_W = 3
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [CTRL_W-1:0] in_ctrl;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [CTRL_W-1:0] out_ctrl;
   logic [1:0]        occupancy;
   logic [15:0]       stall_cnt;

   modport master (
      output in_valid, in_data, in_ctrl, out_ready,
      input  in_ready, out_valid, out_data, out_ctrl, occupancy, stall_cnt
   );

   modport slave (
      input  in_valid, in_data, in_ctrl, out_ready,
      output in_ready, out_valid, out_data, out_ctrl, occupancy, stall_cnt
   );
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with bubble-as-NOP control and stall counter.
// Define PIPE_STAGE_REG_SKID_EN for a skid slot and fully registered in_ready.
module pipe_stage_reg #(
   parameter int DATA_W = 96,
   parameter int CTRL_W = 3
) (
   input logic          clk,
   input logic          reset,
   input logic          flush,
   pipe_stage_reg_if.slave bus
);
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t            state;
   logic [DATA_W-1:0] head_data;
   logic [CTRL_W-1:0] head_ctrl;
`ifdef PIPE_STAGE_REG_SKID_EN
   logic [DATA_W-1:0] skid_data;
   logic [CTRL_W-1:0] skid_ctrl;
`endif
   logic              rdy_q;
   logic [15:0]       stall_q;
   logic              valid;
   logic              ready;
   logic              accept;
   logic              emit;

   assign valid = (state != EMPTY);

`ifdef PIPE_STAGE_REG_SKID_EN
   assign ready = rdy_q;
`else
   // rdy_q keeps in_ready low during reset and until the first edge after it
   assign ready = rdy_q & (!valid | bus.out_ready);
`endif

   assign accept = bus.in_valid & ready;
   assign emit   = valid & bus.out_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= EMPTY;
         head_data <= '0;
         head_ctrl <= '0;
`ifdef PIPE_STAGE_REG_SKID_EN
         skid_data <= '0;
         skid_ctrl <= '0;
`endif
         rdy_q     <= 1'b0;
         stall_q   <= '0;
      end else begin
         if (valid && !bus.out_ready && stall_q != 16'hFFFF)
            stall_q <= stall_q + 16'd1;
         rdy_q <= 1'b1;
         if (flush) begin
            state <= EMPTY;
         end else begin
            unique case (state)
               EMPTY: begin
                  if (accept) begin
                     head_data <= bus.in_data;
                     head_ctrl <= bus.in_ctrl;
                     state     <= ONE;
                  end
               end
               ONE: begin
`ifdef PIPE_STAGE_REG_SKID_EN
                  if (accept && !emit) begin
                     skid_data <= bus.in_data;
                     skid_ctrl <= bus.in_ctrl;
                     state     <= FULL;
                     rdy_q     <= 1'b0;
                  end else if (accept) begin
                     head_data <= bus.in_data;
                     head_ctrl <= bus.in_ctrl;
                  end else if (emit) begin
                     state <= EMPTY;
                  end
`else
                  if (accept) begin
                     head_data <= bus.in_data;
                     head_ctrl <= bus.in_ctrl;
                  end else if (emit) begin
                     state <= EMPTY;
                  end
`endif
               end
               FULL: begin
`ifdef PIPE_STAGE_REG_SKID_EN
                  if (emit) begin
                     head_data <= skid_data;
                     head_ctrl <= skid_ctrl;
                     state     <= ONE;
                  end else begin
                     rdy_q <= 1'b0;
                  end
`else
                  state <= EMPTY;
`endif
               end
               default: state <= EMPTY;
            endcase
         end
      end
   end

   assign bus.in_ready  = ready;
   assign bus.out_valid = valid;
   assign bus.out_data  = head_data;
   assign bus.out_ctrl  = valid ? head_ctrl : '0;
   assign bus.occupancy = state;
   assign bus.stall_cnt = stall_q;
endmodule
